// File: rtl/controller_modulo.sv
// Control FSM for the modulo datapath: computes Zahl1 mod Zahl2 by repeated compare/subtract,
// sequencing datapath write-backs and ALU mode, and reporting done/error with an iteration count.
module controller_modulo #(
   parameter int         ALU_LAT  = 2,
   parameter logic [15:0] MAX_ITER = 16'hFFFF,
   parameter logic [2:0]  ALU_SUB  = 3'd1,
   parameter logic [2:0]  ALU_LT   = 3'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [15:0] Zahl1_i,
   input  logic [15:0] Zahl2_i,
   input  logic        valid_i,
   output logic [2:0]  alu_mode_o,
   output logic        wren_update_Zahlen_o,
   output logic        wren_Zahl1_to_erg_o,
   output logic        wren_term_erg_o,
   output logic        wren_res_to_erg_o,
   output logic        erg_to_alu_a_o,
   output logic        Zahl2_to_alu_b_o,
   output logic        check_for_termination_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] iter_o
);

   typedef enum logic [3:0] {IDLE, LOAD, INIT, CMP, TWB, CHK, SUB, RWB, DONE, ERR} state_t;

   localparam logic [15:0] LAT_LAST = 16'(ALU_LAT - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] wait_cnt;
   logic        bad_operands;

   assign bad_operands = (Zahl2_i == 16'd0) || ($signed(Zahl2_i) < 0) || ($signed(Zahl1_i) < 0);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_i) state_next = bad_operands ? ERR : LOAD;
         end
         LOAD: state_next = INIT;
         INIT: state_next = CMP;
         CMP:  if (wait_cnt == LAT_LAST) state_next = TWB;
         TWB:  state_next = CHK;
         CHK: begin
            if (valid_i)                 state_next = DONE;
            else if (iter_o == MAX_ITER) state_next = ERR;
            else                         state_next = SUB;
         end
         SUB:  if (wait_cnt == LAT_LAST) state_next = RWB;
         RWB:  state_next = CMP;
         DONE: state_next = IDLE;
         ERR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they equal a Moore decode of the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                   <= IDLE;
         wait_cnt                <= 16'd0;
         iter_o                  <= 16'd0;
         alu_mode_o              <= 3'd0;
         wren_update_Zahlen_o    <= 1'b0;
         wren_Zahl1_to_erg_o     <= 1'b0;
         wren_term_erg_o         <= 1'b0;
         wren_res_to_erg_o       <= 1'b0;
         erg_to_alu_a_o          <= 1'b0;
         Zahl2_to_alu_b_o        <= 1'b0;
         check_for_termination_o <= 1'b0;
         busy_o                  <= 1'b0;
         done_o                  <= 1'b0;
         err_o                   <= 1'b0;
      end else begin
         state <= state_next;

         if ((state_next == state) && (state == CMP || state == SUB))
            wait_cnt <= wait_cnt + 16'd1;
         else
            wait_cnt <= 16'd0;

         if (state == IDLE && state_next == LOAD)
            iter_o <= 16'd0;
         else if (state == RWB && iter_o != 16'hFFFF)
            iter_o <= iter_o + 16'd1;

         if (state_next == CMP || state_next == TWB)
            alu_mode_o <= ALU_LT;
         else if (state_next == SUB || state_next == RWB)
            alu_mode_o <= ALU_SUB;
         else
            alu_mode_o <= 3'd0;

         wren_update_Zahlen_o    <= (state_next == LOAD);
         wren_Zahl1_to_erg_o     <= (state_next == INIT);
         wren_term_erg_o         <= (state_next == TWB);
         wren_res_to_erg_o       <= (state_next == RWB);
         erg_to_alu_a_o          <= (state_next == CMP) || (state_next == TWB) ||
                                    (state_next == SUB) || (state_next == RWB);
         Zahl2_to_alu_b_o        <= (state_next == CMP) || (state_next == TWB) ||
                                    (state_next == SUB) || (state_next == RWB);
         check_for_termination_o <= (state_next == CHK);
         busy_o                  <= (state_next != IDLE) && (state_next != DONE) &&
                                    (state_next != ERR);
         done_o                  <= (state_next == DONE) || (state_next == ERR);
         err_o                   <= (state_next == ERR);
      end
   end

endmodule

// File: tb/tb_controller_modulo.sv
// Scoreboard bench: three controller instances (ALU_LAT 2/1/3, last with MAX_ITER=2) each driving
// a small behavioural datapath; stimulus pushes expected completions, per-instance monitors pop and compare.
module tb_controller_modulo;

   localparam int NI = 3;

   typedef struct {
      int   cyc;
      logic err;
      int   iter;
      int   erg;
      logic chk_iter;
      logic chk_erg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] zahl1 = 16'd0;
   logic [15:0] zahl2 = 16'd0;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[NI][$];

   logic [NI-1:0] outs_zero;
   logic [2:0]    mode_v [NI];
   logic [15:0]   iter_v [NI];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : 3;
   endfunction

   function automatic int max_of(int g);
      return (g == 2) ? 2 : 65535;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int          L = (gi == 0) ? 2 : (gi == 1) ? 1 : 3;
      localparam logic [15:0] M = (gi == 2) ? 16'd2 : 16'hFFFF;

      logic [2:0]  alu_mode;
      logic        w_upd, w_z1, w_term, w_res, sel_a, sel_b, chk, busy, done, err, valid;
      logic [15:0] iter;
      logic [15:0] z1 = 16'd0, z2 = 16'd0, erg = 16'd0, term = 16'd0;
      logic [15:0] alu_a, alu_b, alu_res;
      logic [2:0]  pm = 3'd0;
      logic        pa = 1'b0, pb = 1'b0;
      exp_t        e;

      controller_modulo #(.ALU_LAT(L), .MAX_ITER(M)) dut (
         .clk(clk), .rst(rst), .start_i(start), .Zahl1_i(zahl1), .Zahl2_i(zahl2),
         .valid_i(valid), .alu_mode_o(alu_mode), .wren_update_Zahlen_o(w_upd),
         .wren_Zahl1_to_erg_o(w_z1), .wren_term_erg_o(w_term), .wren_res_to_erg_o(w_res),
         .erg_to_alu_a_o(sel_a), .Zahl2_to_alu_b_o(sel_b), .check_for_termination_o(chk),
         .busy_o(busy), .done_o(done), .err_o(err), .iter_o(iter)
      );

      // Behavioural datapath: ALU result is ready well within ALU_LAT, so it is combinational here.
      assign alu_a   = sel_a ? erg : 16'd0;
      assign alu_b   = sel_b ? z2 : 16'd0;
      assign alu_res = (alu_mode == 3'd1) ? alu_a - alu_b :
                       (alu_mode == 3'd2) ? {15'd0, ($signed(alu_a) < $signed(alu_b))} : 16'd0;
      assign valid   = chk & term[0];

      always @(posedge clk) begin
         if (w_upd) begin
            z1 <= zahl1;
            z2 <= zahl2;
         end
         if (w_z1)   erg  <= z1;
         if (w_term) term <= alu_res;
         if (w_res)  erg  <= alu_res;
      end

      assign outs_zero[gi] = ~|{alu_mode, w_upd, w_z1, w_term, w_res, sel_a, sel_b, chk, busy, done, err};
      assign mode_v[gi]    = alu_mode;
      assign iter_v[gi]    = iter;

      always @(negedge clk) begin
         checks++;
         if ($countones({w_upd, w_z1, w_term, w_res}) > 1) begin
            failures++;
            $display("FAIL onehot inst%0d cyc=%0d got=%b required at most one high", gi, cyc,
                     {w_upd, w_z1, w_term, w_res});
         end
         if (w_term || w_res) begin
            checks++;
            if (pm != alu_mode || !pa || !pb || !sel_a || !sel_b ||
                alu_mode != (w_term ? 3'd2 : 3'd1)) begin
               failures++;
               $display("FAIL stable inst%0d cyc=%0d got mode %0d->%0d sel %b%b->%b%b required mode %0d held, sel 11",
                        gi, cyc, pm, alu_mode, pa, pb, sel_a, sel_b, w_term ? 2 : 1);
            end
         end
         if (!rst && done) begin
            checks++;
            if (exp_q[gi].size() == 0) begin
               failures++;
               $display("FAIL unexpected_done inst%0d cyc=%0d got done=1 required none", gi, cyc);
            end else begin
               e = exp_q[gi].pop_front();
               if (cyc != e.cyc) begin
                  failures++;
                  $display("FAIL latency inst%0d got cyc=%0d required cyc=%0d", gi, cyc, e.cyc);
               end
               checks++;
               if (err !== e.err) begin
                  failures++;
                  $display("FAIL err inst%0d cyc=%0d got=%b required=%b", gi, cyc, err, e.err);
               end
               checks++;
               if ({w_upd, w_z1, w_term, w_res} != 4'b0) begin
                  failures++;
                  $display("FAIL wren_at_done inst%0d got=%b required=0000", gi, {w_upd, w_z1, w_term, w_res});
               end
               if (e.chk_iter) begin
                  checks++;
                  if (int'(iter) != e.iter) begin
                     failures++;
                     $display("FAIL iter inst%0d got=%0d required=%0d", gi, iter, e.iter);
                  end
               end
               if (e.chk_erg) begin
                  checks++;
                  if (int'(erg) != e.erg) begin
                     failures++;
                     $display("FAIL ergebnis inst%0d got=%0d required=%0d", gi, erg, e.erg);
                  end
               end
               $display("done inst%0d cyc=%0d err=%b iter=%0d ergebnis=%0d", gi, cyc, err, iter, erg);
            end
         end
         pm <= alu_mode;
         pa <= sel_a;
         pb <= sel_b;
      end
   end

   task automatic wait_all_done();
      int n = 0;
      while (n < 3000 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("FAIL timeout got pending=%0d/%0d/%0d required 0", exp_q[0].size(), exp_q[1].size(),
                  exp_q[2].size());
         for (int g = 0; g < NI; g++) exp_q[g].delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // n = subtractions needed, r = remainder; both hand-computed in the vector table.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int n, input int r,
                         input int pulse_at);
      exp_t x;
      int   l, m, k;
      logic bad;
      @(negedge clk);
      zahl1 = a;
      zahl2 = b;
      start = 1'b1;
      bad = (b == 16'd0) || b[15] || a[15];
      for (int g = 0; g < NI; g++) begin
         l = lat_of(g);
         m = max_of(g);
         if (bad) begin
            x = '{cyc: cyc + 1, err: 1'b1, iter: 0, erg: 0, chk_iter: 1'b0, chk_erg: 1'b0};
         end else begin
            k = (n > m) ? m : n;
            x.cyc      = cyc + 2 + (2 * l + 3) * k + (l + 2) + 1;
            x.err      = (n > m);
            x.iter     = k;
            x.erg      = r;
            x.chk_iter = 1'b1;
            x.chk_erg  = (n <= m);
         end
         exp_q[g].push_back(x);
      end
      $display("start %0d mod %0d (expected subtractions %0d, remainder %0d)", $signed(a), $signed(b), n, r);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      zahl1 = 16'h1234;
      zahl2 = 16'h0007;
      if (pulse_at > 0) begin
         repeat (pulse_at) @(negedge clk);
         zahl1 = 16'd3;
         zahl2 = 16'd5;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_all_done();
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      checks++;
      if (outs_zero != '1 || iter_v[0] != 16'd0) begin
         failures++;
         $display("FAIL reset_state got zero=%b iter=%0d required zero=111 iter=0", outs_zero, iter_v[0]);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_op(16'd17,  16'd5, 3,   2, 0);
      run_op(16'd3,   16'd5, 0,   3, 0);
      run_op(16'd10,  16'd5, 2,   0, 0);
      run_op(16'd0,   16'd5, 0,   0, 0);
      run_op(16'd0,   16'd0, 0,   0, 0);
      run_op(16'h8000, 16'd5, 0,  0, 0);
      run_op(16'd9,   16'hFFFD, 0, 0, 0);
      run_op(16'd100, 16'd1, 100, 0, 0);
      run_op(16'd17,  16'd5, 3,   2, 8);
      run_op(16'd5,   16'd5, 1,   0, 0);

      // Abort mid-subtract: start pulse while busy, then async reset; no done may follow.
      @(negedge clk);
      zahl1 = 16'd17;
      zahl2 = 16'd5;
      start = 1'b1;
      $display("start 17 mod 5 to be aborted by reset");
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 100 && mode_v[0] != 3'd1) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL reach_sub got mode=%0d required 1 within 100 cycles", mode_v[0]);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (outs_zero != '1 || iter_v[0] != 16'd0 || iter_v[1] != 16'd0 || iter_v[2] != 16'd0) begin
         failures++;
         $display("FAIL async_reset got zero=%b iter=%0d required zero=111 iter=0", outs_zero, iter_v[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (outs_zero != '1) begin
         failures++;
         $display("FAIL after_reset_idle got zero=%b required 111", outs_zero);
      end
      $display("reset abort checked");

      run_op(16'd3, 16'd5, 0, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
